// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and launch sequencer feeding the UART transmitter
// Bytes are queued, handed out one per valid pulse, and the next waits for tx done or timeout.
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int DONE_TIMEOUT = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_Wr_En,
  input  logic [7:0]               i_Wr_Byte,
  input  logic                     i_Clr_Err,
  output logic                     o_Full,
  output logic                     o_Empty,
  output logic [$clog2(DEPTH):0]   o_Count,
  output logic                     o_Overflow,
  output logic                     o_Timeout,
  output logic                     o_TX_Data_Valid,
  output logic [7:0]               o_TX_Byte,
  input  logic                     i_TX_Done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (DONE_TIMEOUT > 0) ? $clog2(DONE_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'((DONE_TIMEOUT > 0) ? DONE_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [TW-1:0]   timer, timer_n;
  logic [CW-1:0]   count_n;
  logic            pop, push, ovf_evt, to_hit;
  logic [7:0]      mem [DEPTH];

  always_comb begin
    state_n = state;
    timer_n = timer;
    pop     = 1'b0;
    to_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (o_Count != '0) begin
          pop     = 1'b1;
          state_n = LAUNCH;
        end
      end
      LAUNCH: begin
        state_n = WAIT_DONE;
        timer_n = '0;
      end
      WAIT_DONE: begin
        // A done pulse on the expiry cycle counts as a normal completion
        if (i_TX_Done) begin
          state_n = IDLE;
        end else if (DONE_TIMEOUT != 0 && timer == TO_LAST) begin
          to_hit  = 1'b1;
          state_n = IDLE;
        end else if (timer != '1) begin
          timer_n = timer + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    push    = i_Wr_En && ((o_Count != FULL_CNT) || pop);
    ovf_evt = i_Wr_En && !push;
    count_n = o_Count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_Wr_Byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      timer           <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      o_Count         <= '0;
      o_Full          <= 1'b0;
      o_Empty         <= 1'b1;
      o_Overflow      <= 1'b0;
      o_Timeout       <= 1'b0;
      o_TX_Data_Valid <= 1'b0;
      o_TX_Byte       <= 8'h00;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      o_Count <= count_n;
      o_Full  <= (count_n == FULL_CNT);
      o_Empty <= (count_n == '0);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        o_TX_Byte <= mem[rd_ptr];
      end
      o_TX_Data_Valid <= (state_n == LAUNCH);
      // New errors override a same-edge clear
      o_Overflow      <= (o_Overflow & ~i_Clr_Err) | ovf_evt;
      o_Timeout       <= (o_Timeout & ~i_Clr_Err) | to_hit;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int TMO   = 20;

  logic       clk, rst, i_Wr_En, i_Clr_Err, i_TX_Done;
  logic [7:0] i_Wr_Byte;
  logic       o_Full, o_Empty, o_Overflow, o_Timeout, o_TX_Data_Valid;
  logic [4:0] o_Count;
  logic [7:0] o_TX_Byte;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_q[$];
  int         m_phase;
  int         m_waited;
  bit         m_ovf, m_tmo;
  logic [7:0] m_cur;

  bit         loop_en, force_done;
  int         dmax, done_cd, k, npulse;
  logic [7:0] seen[$];

  uart_tx_fifo #(.DEPTH(DEPTH), .DONE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .i_Wr_En(i_Wr_En), .i_Wr_Byte(i_Wr_Byte),
    .i_Clr_Err(i_Clr_Err), .o_Full(o_Full), .o_Empty(o_Empty), .o_Count(o_Count),
    .o_Overflow(o_Overflow), .o_Timeout(o_Timeout), .o_TX_Data_Valid(o_TX_Data_Valid),
    .o_TX_Byte(o_TX_Byte), .i_TX_Done(i_TX_Done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_phase  = 0;
    m_waited = 0;
    m_ovf    = 0;
    m_tmo    = 0;
    m_cur    = 8'h00;
  endtask

  // phase 0: ready to hand out a byte, 1: pulse cycle, 2: awaiting done
  task automatic model_step();
    bit pop, acc, ovf_evt, tmo_evt;
    if (rst) begin
      model_reset();
      return;
    end
    pop     = (m_phase == 0) && (m_q.size() > 0);
    acc     = i_Wr_En && ((m_q.size() < DEPTH) || pop);
    ovf_evt = i_Wr_En && !acc;
    tmo_evt = 0;
    case (m_phase)
      0: if (pop) begin m_cur = m_q.pop_front(); m_phase = 1; end
      1: begin m_phase = 2; m_waited = 0; end
      default: begin
        m_waited++;
        if (i_TX_Done) m_phase = 0;
        else if (m_waited == TMO) begin tmo_evt = 1; m_phase = 0; end
      end
    endcase
    if (acc) m_q.push_back(i_Wr_Byte);
    m_ovf = (m_ovf && !i_Clr_Err) || ovf_evt;
    m_tmo = (m_tmo && !i_Clr_Err) || tmo_evt;
  endtask

  task automatic compare_outputs();
    chk("valid", o_TX_Data_Valid, m_phase == 1);
    chk("byte", o_TX_Byte, m_cur);
    chk("count", o_Count, m_q.size());
    chk("full", o_Full, m_q.size() == DEPTH);
    chk("empty", o_Empty, m_q.size() == 0);
    chk("overflow", o_Overflow, m_ovf);
    chk("timeout", o_Timeout, m_tmo);
  endtask

  task automatic tick(input bit wr, input logic [7:0] b, input bit clr);
    i_Wr_En   = wr;
    i_Wr_Byte = b;
    i_Clr_Err = clr;
    i_TX_Done = force_done || (done_cd == 1);
    force_done = 0;
    if (done_cd > 0) done_cd--;
    if (loop_en && o_TX_Data_Valid) done_cd = $urandom_range(dmax, 1);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
    if (o_TX_Data_Valid) seen.push_back(o_TX_Byte);
  endtask

  initial begin
    rst = 1; i_Wr_En = 0; i_Wr_Byte = 0; i_Clr_Err = 0; i_TX_Done = 0;
    loop_en = 0; force_done = 0; done_cd = 0; dmax = 6;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_empty", o_Empty, 1);
    chk("rst_count", o_Count, 0);
    chk("rst_full", o_Full, 0);
    chk("rst_valid", o_TX_Data_Valid, 0);
    chk("rst_byte", o_TX_Byte, 8'h00);
    chk("rst_ovf", o_Overflow, 0);
    chk("rst_tmo", o_Timeout, 0);
    rst = 0;

    tick(1, 8'hA5, 0);
    chk("t1_count", o_Count, 1);
    chk("t1_valid_early", o_TX_Data_Valid, 0);
    tick(0, 8'h00, 0);
    chk("t1_valid", o_TX_Data_Valid, 1);
    chk("t1_byte", o_TX_Byte, 8'hA5);
    chk("t1_empty", o_Empty, 1);
    npulse = 0;
    repeat (12) begin
      tick(0, 8'h00, 0);
      if (o_TX_Data_Valid) npulse++;
    end
    chk("t1_no_second", npulse, 0);
    chk("t1_hold", o_TX_Byte, 8'hA5);
    force_done = 1;
    repeat (3) tick(0, 8'h00, 0);
    chk("t1_after_done", o_TX_Data_Valid, 0);

    loop_en = 1; dmax = 6; seen.delete();
    for (int i = 0; i < 16; i++) tick(1, 8'(i), 0);
    k = 0;
    while (seen.size() < 16 && k < 500) begin tick(0, 8'h00, 0); k++; end
    chk("t2_seen_n", seen.size(), 16);
    for (int i = 0; i < 16 && i < seen.size(); i++) chk("t2_order", seen[i], i);
    chk("t2_ovf", o_Overflow, 0);
    repeat (12) tick(0, 8'h00, 0);
    loop_en = 0; done_cd = 0;
    chk("t2_drained", o_Empty, 1);

    for (int i = 0; i < 17; i++) tick(1, 8'(8'h40 + i), 0);
    chk("t3_full", o_Full, 1);
    chk("t3_count", o_Count, 16);
    chk("t3_no_ovf", o_Overflow, 0);
    tick(1, 8'hEE, 0);
    chk("t3_ovf", o_Overflow, 1);
    chk("t3_count_kept", o_Count, 16);
    tick(1, 8'hEF, 1);
    chk("t3_err_wins", o_Overflow, 1);
    tick(0, 8'h00, 1);
    chk("t3_cleared", o_Overflow, 0);

    force_done = 1;
    tick(0, 8'h00, 0);
    tick(1, 8'h77, 0);
    chk("t4_count", o_Count, 16);
    chk("t4_full", o_Full, 1);
    chk("t4_no_ovf", o_Overflow, 0);
    chk("t4_valid", o_TX_Data_Valid, 1);
    chk("t4_byte", o_TX_Byte, 8'h41);

    k = 0;
    while (!o_Timeout && k < 100) begin tick(0, 8'h00, 0); k++; end
    chk("t5_cycles", k, 21);
    chk("t5_tmo", o_Timeout, 1);
    tick(0, 8'h00, 0);
    chk("t5_next_valid", o_TX_Data_Valid, 1);
    chk("t5_next_byte", o_TX_Byte, 8'h42);
    tick(0, 8'h00, 1);
    chk("t5_cleared", o_Timeout, 0);

    loop_en = 1; dmax = 3; k = 0;
    while (o_Count != 5 && k < 400) begin tick(0, 8'h00, 0); k++; end
    loop_en = 0; done_cd = 0; k = 0;
    while (m_phase != 2 && k < 10) begin tick(0, 8'h00, 0); k++; end
    chk("t6_in_wait", m_phase, 2);
    #2 rst = 1;
    model_reset();
    #1;
    chk("t6_count", o_Count, 0);
    chk("t6_empty", o_Empty, 1);
    chk("t6_valid", o_TX_Data_Valid, 0);
    chk("t6_byte", o_TX_Byte, 8'h00);
    @(negedge clk);
    compare_outputs();
    rst = 0;
    force_done = 1;
    npulse = 0;
    repeat (4) begin
      tick(0, 8'h00, 0);
      if (o_TX_Data_Valid) npulse++;
    end
    chk("t6_no_launch", npulse, 0);

    loop_en = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) dmax = $urandom_range(25, 1);
      tick($urandom_range(99, 0) < 40, 8'($urandom), $urandom_range(31, 0) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
